serial_ripple_subtractor: RTL and testbench

Bit-serial, multi-cycle subtractor that computes diff = a - b - bin, one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow. It is the inverse-operation companion to the team's combinational ripple-carry adder. It serves area-constrained datapaths that can tolerate WIDTH-cycle latency, and uses a start/ready/done handshake toward its controller.

---
 rtl/serial_ripple_subtractor_pkg.sv | 15 +
 rtl/serial_ripple_subtractor_full_subtractor.sv | 13 +
 rtl/serial_ripple_subtractor.sv | 115 +++++++++++
 tb/tb_serial_ripple_subtractor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_ripple_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit counter width: clog2(width), never below one bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module serial_ripple_subtractor_full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// behind a start/ready/done handshake.
module serial_ripple_subtractor
   import serial_ripple_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_e             state;
   state_e             state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   diff_sh;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               last_c;
   logic               d_c;
   logic               bo_c;

   serial_ripple_subtractor_full_subtractor u_full_subtractor (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .bi (borrow),
      .d  (d_c),
      .bo (bo_c)
   );

   // Next-state logic
   always_comb begin
      state_nxt = state;
      last_c    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            last_c = (cnt == CNT_W'(WIDTH - 1));
            if (last_c) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with handshake flags registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == IDLE);
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
      end
   end

   // Serial datapath; result registers only move on the final bit
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         borrow  <= 1'b0;
         cnt     <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  diff_sh <= '0;
                  borrow  <= bin;
                  cnt     <= '0;
               end
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               diff_sh <= {d_c, diff_sh[WIDTH-1:1]};
               borrow  <= bo_c;
               cnt     <= cnt + CNT_W'(1);
               if (last_c) begin
                  diff <= {d_c, diff_sh[WIDTH-1:1]};
                  bout <= bo_c;
                  // Signed overflow: borrow into MSB differs from borrow out of it
                  ovf  <= borrow ^ bo_c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Self-checking bench for serial_ripple_subtractor (WIDTH=4).
module tb_serial_ripple_subtractor;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a_i;
   logic [W-1:0] b_i;
   logic         bin_i;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   int total = 0;
   int bad   = 0;
   logic [W-1:0] last_diff;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } vec_t;

   vec_t vecs[6];

   serial_ripple_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a_i),
      .b     (b_i),
      .bin   (bin_i),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                 output logic [W-1:0] d, output logic bo, output logic ov);
      int u;
      int s;
      u  = int'(a) - int'(b) - int'(bin);
      s  = int'($signed(a)) - int'($signed(b)) - int'(bin);
      d  = W'(u);
      bo = (u < 0);
      ov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
   endfunction

   // One full handshake, entered and left on a negedge with the DUT idle
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
      int   lat;
      logic hold_ok;
      a_i = a; b_i = b; bin_i = bin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("ready_after_start", 32'(ready), 32'd0);
      lat = 0;
      hold_ok = 1'b1;
      while (!done && lat < 20) begin
         if (diff !== last_diff) hold_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(W));
      chk("diff_hold", 32'(hold_ok), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("diff", 32'(diff), 32'(ed));
      chk("bout", 32'(bout), 32'(eb));
      chk("ovf", 32'(ovf), 32'(eo));
      last_diff = ed;
      @(negedge clk);
      chk("ready_after_done", 32'(ready), 32'd1);
      chk("done_pulse_len", 32'(done), 32'd0);
   endtask

   initial begin
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      logic [W-1:0] qa[3];
      logic [W-1:0] qb[3];
      logic         qbin[3];

      vecs[0] = '{a: 4'b0101, b: 4'b0011, bin: 1'b0, diff: 4'b0010, bout: 1'b0, ovf: 1'b0};
      vecs[1] = '{a: 4'b0001, b: 4'b0010, bin: 1'b0, diff: 4'b1111, bout: 1'b1, ovf: 1'b0};
      vecs[2] = '{a: 4'b1000, b: 4'b0001, bin: 1'b0, diff: 4'b0111, bout: 1'b0, ovf: 1'b1};
      vecs[3] = '{a: 4'b0111, b: 4'b1111, bin: 1'b0, diff: 4'b1000, bout: 1'b1, ovf: 1'b1};
      vecs[4] = '{a: 4'b0000, b: 4'b1111, bin: 1'b1, diff: 4'b0000, bout: 1'b1, ovf: 1'b0};
      vecs[5] = '{a: 4'b1111, b: 4'b1111, bin: 1'b1, diff: 4'b1111, bout: 1'b1, ovf: 1'b0};

      rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; bin_i = 1'b0;
      last_diff = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);

      for (int i = 0; i < 6; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].ovf);

      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rbin;
         ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
         model(ra, rb, rbin, ed, eb, eo);
         do_op(ra, rb, rbin, ed, eb, eo);
      end

      // start held high: accepted every W+2 cycles, inputs changing each cycle
      for (int k = 0; k <= 3 * (W + 2); k++) begin
         if (k % (W + 2) == W + 1) begin
            chk("held_done", 32'(done), 32'd1);
            model(qa[k / (W + 2)], qb[k / (W + 2)], qbin[k / (W + 2)], ed, eb, eo);
            chk("held_diff", 32'(diff), 32'(ed));
            chk("held_bout", 32'(bout), 32'(eb));
            chk("held_ovf", 32'(ovf), 32'(eo));
            last_diff = ed;
         end else begin
            chk("held_no_done", 32'(done), 32'd0);
            chk("held_diff_hold", 32'(diff), 32'(last_diff));
         end
         a_i = W'($urandom); b_i = W'($urandom); bin_i = 1'($urandom);
         if (k == 3 * (W + 2)) begin
            start = 1'b0;
         end else begin
            start = 1'b1;
            if (k % (W + 2) == 0) begin
               qa[k / (W + 2)]   = a_i;
               qb[k / (W + 2)]   = b_i;
               qbin[k / (W + 2)] = bin_i;
            end
         end
         @(negedge clk);
      end

      // Make sure a nonzero result is held before the abort
      do_op(4'b1001, 4'b0010, 1'b0, 4'b0111, 1'b0, 1'b1);

      // Reset on the second RUN cycle aborts without a done pulse
      a_i = 4'b0110; b_i = 4'b0001; bin_i = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_diff", 32'(diff), 32'd0);
      chk("abort_bout", 32'(bout), 32'd0);
      chk("abort_ovf", 32'(ovf), 32'd0);
      repeat (W + 2) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done), 32'd0);
      end
      last_diff = '0;
      do_op(4'b1010, 4'b0101, 1'b1, 4'b0100, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
